// File: rtl/rc4_decrypt_core.sv
// RC4 decryption engine: builds S in an external 256x8 RAM, runs the key
// schedule, then streams MSG_LEN ciphertext bytes through the keystream into
// a plaintext RAM. Optional lowercase/space check aborts on the first bad byte.
//
// state  | meaning
// IDLE   | waiting for start; results held
// INIT   | S[i] = i, one write per cycle
// KSA    | key schedule, 5 cycles per i
// PRGA   | keystream + XOR, 7 cycles per message byte
// FINISH | one-cycle done pulse, valid reflects the check outcome
module rc4_decrypt_core #(
  parameter int KEY_BYTES  = 3,
  parameter int MSG_LEN    = 32,
  parameter int CHECK_MODE = 1,
  localparam int AW = ($clog2(MSG_LEN) < 1) ? 1 : $clog2(MSG_LEN)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic                   busy,
  output logic                   done,
  output logic                   valid,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wdata,
  output logic                   s_we,
  input  logic [7:0]             s_rdata,
  output logic [AW-1:0]          e_addr,
  input  logic [7:0]             e_rdata,
  output logic [AW-1:0]          d_addr,
  output logic [7:0]             d_wdata,
  output logic                   d_we
);

  typedef enum logic [2:0] {IDLE, INIT, KSA, PRGA, FINISH} state_t;

  state_t                 state, state_next;
  logic [2:0]             phase;
  logic [7:0]             i, j, si, sj, ebyte;
  logic [AW-1:0]          k;
  logic [3:0]             kpos;
  logic [8*KEY_BYTES-1:0] key_reg;
  logic                   valid_r;
  logic [7:0]             kbyte, pbyte;
  logic                   bad, last_byte;

  // Key byte for the current KSA step (kpos counts down so byte 0 is the MSB),
  // the candidate plaintext byte, and the abort/last-byte conditions.
  always_comb begin
    kbyte     = 8'(key_reg >> {kpos, 3'b000});
    pbyte     = s_rdata ^ ebyte;
    bad       = (CHECK_MODE != 0) &&
                !(((pbyte >= 8'h61) && (pbyte <= 8'h7a)) || (pbyte == 8'h20));
    last_byte = (k == AW'(MSG_LEN - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state and memory-port control; all outputs idle to zero.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    s_addr     = 8'd0;
    s_wdata    = 8'd0;
    s_we       = 1'b0;
    d_wdata    = 8'd0;
    d_we       = 1'b0;
    case (state)
      IDLE: if (start) state_next = INIT;
      INIT: begin
        busy    = 1'b1;
        s_we    = 1'b1;
        s_addr  = i;
        s_wdata = i;
        if (i == 8'hff) state_next = KSA;
      end
      KSA: begin
        busy = 1'b1;
        case (phase)
          3'd0: s_addr = i;
          3'd2: s_addr = j;
          3'd3: begin s_addr = i; s_wdata = s_rdata; s_we = 1'b1; end
          3'd4: begin
            s_addr  = j;
            s_wdata = si;
            s_we    = 1'b1;
            if (i == 8'hff) state_next = PRGA;
          end
          default: ;
        endcase
      end
      PRGA: begin
        busy = 1'b1;
        case (phase)
          3'd0: s_addr = i + 8'd1;
          3'd2: s_addr = j;
          3'd3: begin s_addr = i; s_wdata = s_rdata; s_we = 1'b1; end
          3'd4: begin s_addr = j; s_wdata = si; s_we = 1'b1; end
          3'd5: s_addr = si + sj;
          3'd6: begin
            d_we    = 1'b1;
            d_wdata = pbyte;
            if (last_byte || bad) state_next = FINISH;
          end
          default: ;
        endcase
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign e_addr = k;
  assign d_addr = k;
  assign valid  = valid_r;

  // Datapath: indices, captured S values, key and result flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase   <= 3'd0;
      i       <= 8'd0;
      j       <= 8'd0;
      si      <= 8'd0;
      sj      <= 8'd0;
      ebyte   <= 8'd0;
      k       <= '0;
      kpos    <= 4'd0;
      key_reg <= '0;
      valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          key_reg <= key;
          valid_r <= 1'b0;
          phase   <= 3'd0;
          i       <= 8'd0;
          j       <= 8'd0;
          k       <= '0;
          kpos    <= 4'(KEY_BYTES - 1);
        end
        INIT: i <= i + 8'd1;
        KSA: begin
          phase <= phase + 3'd1;
          if (phase == 3'd1) begin
            si <= s_rdata;
            j  <= j + s_rdata + kbyte;
          end
          if (phase == 3'd4) begin
            phase <= 3'd0;
            i     <= i + 8'd1;
            kpos  <= (kpos == 4'd0) ? 4'(KEY_BYTES - 1) : kpos - 4'd1;
            if (i == 8'hff) j <= 8'd0;
          end
        end
        PRGA: begin
          phase <= phase + 3'd1;
          case (phase)
            3'd0: i <= i + 8'd1;
            3'd1: begin
              si    <= s_rdata;
              j     <= j + s_rdata;
              ebyte <= e_rdata;
            end
            3'd3: sj <= s_rdata;
            3'd6: begin
              phase <= 3'd0;
              if (last_byte || bad) valid_r <= !bad;
              else                  k <= k + 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// Scoreboard bench for rc4_decrypt_core: two instances (checked / unchecked
// mode) with behavioural RAM/ROM models and a plain RC4 reference model.
module tb_rc4_decrypt_core;

  localparam int BOUND_A = 256 + 256*8 + 5*12 + 4;
  localparam int BOUND_B = 256 + 256*8 + 9*12 + 4;

  logic clk = 1'b0;
  logic reset_n;
  logic start_a, start_b;
  logic [31:0] key_a;
  logic [23:0] key_b;

  logic busy_a, done_a, valid_a, s_we_a, d_we_a;
  logic [7:0] s_addr_a, s_wdata_a, s_rdata_a, e_rdata_a, d_wdata_a;
  logic [2:0] e_addr_a, d_addr_a;
  logic busy_b, done_b, valid_b, s_we_b, d_we_b;
  logic [7:0] s_addr_b, s_wdata_b, s_rdata_b, e_rdata_b, d_wdata_b;
  logic [3:0] e_addr_b, d_addr_b;

  logic [7:0] s_mem_a [256];
  logic [7:0] e_mem_a [8];
  logic [7:0] s_mem_b [256];
  logic [7:0] e_mem_b [16];

  int exp_addr_a[$], exp_data_a[$], exp_addr_b[$], exp_data_b[$];
  bit exp_valid_a[$], exp_valid_b[$];
  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  rc4_decrypt_core #(.KEY_BYTES(4), .MSG_LEN(5), .CHECK_MODE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .key(key_a),
    .busy(busy_a), .done(done_a), .valid(valid_a),
    .s_addr(s_addr_a), .s_wdata(s_wdata_a), .s_we(s_we_a), .s_rdata(s_rdata_a),
    .e_addr(e_addr_a), .e_rdata(e_rdata_a),
    .d_addr(d_addr_a), .d_wdata(d_wdata_a), .d_we(d_we_a));

  rc4_decrypt_core #(.KEY_BYTES(3), .MSG_LEN(9), .CHECK_MODE(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .key(key_b),
    .busy(busy_b), .done(done_b), .valid(valid_b),
    .s_addr(s_addr_b), .s_wdata(s_wdata_b), .s_we(s_we_b), .s_rdata(s_rdata_b),
    .e_addr(e_addr_b), .e_rdata(e_rdata_b),
    .d_addr(d_addr_b), .d_wdata(d_wdata_b), .d_we(d_we_b));

  // Synchronous S RAMs and ciphertext ROMs, one-cycle read latency.
  always @(posedge clk) begin
    if (s_we_a) s_mem_a[s_addr_a] <= s_wdata_a;
    s_rdata_a <= s_mem_a[s_addr_a];
    e_rdata_a <= e_mem_a[e_addr_a];
    if (s_we_b) s_mem_b[s_addr_b] <= s_wdata_b;
    s_rdata_b <= s_mem_b[s_addr_b];
    e_rdata_b <= e_mem_b[e_addr_b];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Plain RC4 over whole arrays; stops after the first failing byte when chk is set.
  function automatic void rc4_model(input byte unsigned kb[$], input byte unsigned e[$],
                                    input bit chk, output byte unsigned d[$], output bit ok);
    int s[256];
    int i, j, t;
    byte unsigned p;
    d = {};
    ok = 1'b1;
    for (int n = 0; n < 256; n++) s[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + s[n] + int'(kb[n % kb.size()])) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int n = 0; n < e.size(); n++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      p = 8'(s[(s[i] + s[j]) % 256]) ^ e[n];
      d.push_back(p);
      if (chk && !(((p >= 8'h61) && (p <= 8'h7a)) || (p == 8'h20))) begin
        ok = 1'b0;
        break;
      end
    end
  endfunction

  // Scoreboard monitors: every plaintext write and every done pulse is matched
  // against the expectations queued by the stimulus.
  always @(negedge clk) begin
    if (d_we_a) begin
      check("d_we_a_vs_s_we_a", s_we_a, 0);
      if (exp_addr_a.size() == 0) check("d_we_a_unexpected", d_we_a, 0);
      else begin
        check("d_addr_a", d_addr_a, exp_addr_a.pop_front());
        check("d_wdata_a", d_wdata_a, exp_data_a.pop_front());
      end
    end
    if (done_a) begin
      if (exp_valid_a.size() == 0) check("done_a_unexpected", done_a, 0);
      else begin
        check("valid_a_at_done", valid_a, exp_valid_a.pop_front());
        check("writes_left_a", exp_addr_a.size(), 0);
        check("busy_a_at_done", busy_a, 0);
      end
    end
    if (d_we_b) begin
      check("d_we_b_vs_s_we_b", s_we_b, 0);
      if (exp_addr_b.size() == 0) check("d_we_b_unexpected", d_we_b, 0);
      else begin
        check("d_addr_b", d_addr_b, exp_addr_b.pop_front());
        check("d_wdata_b", d_wdata_b, exp_data_b.pop_front());
      end
    end
    if (done_b) begin
      if (exp_valid_b.size() == 0) check("done_b_unexpected", done_b, 0);
      else begin
        check("valid_b_at_done", valid_b, exp_valid_b.pop_front());
        check("writes_left_b", exp_addr_b.size(), 0);
      end
    end
  end

  task automatic prep_a(input logic [31:0] key, input byte unsigned e[5], output bit ok);
    byte unsigned kb[$], eq[$], d[$];
    for (int n = 3; n >= 0; n--) kb.push_back(key[8*n +: 8]);
    for (int n = 0; n < 5; n++) begin e_mem_a[n] = e[n]; eq.push_back(e[n]); end
    rc4_model(kb, eq, 1'b1, d, ok);
    foreach (d[n]) begin exp_addr_a.push_back(n); exp_data_a.push_back(int'(d[n])); end
    exp_valid_a.push_back(ok);
    @(negedge clk); key_a = key; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check("busy_a_after_start", busy_a, 1);
    check("valid_a_cleared", valid_a, 0);
  endtask

  task automatic run_a(input logic [31:0] key, input byte unsigned e[5], input int poke_at);
    bit ok;
    int cyc;
    prep_a(key, e, ok);
    cyc = 1;
    while (!done_a && cyc < BOUND_A) begin
      if (cyc == poke_at) begin key_a = ~key; start_a = 1'b1; end
      else start_a = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start_a = 1'b0;
    check("done_a_within_bound", done_a, 1);
    @(negedge clk);
    check("done_a_one_cycle", done_a, 0);
    check("valid_a_held", valid_a, ok);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_b(input logic [23:0] key, input byte unsigned e[9]);
    byte unsigned kb[$], eq[$], d[$];
    bit ok;
    int cyc;
    for (int n = 2; n >= 0; n--) kb.push_back(key[8*n +: 8]);
    for (int n = 0; n < 9; n++) begin e_mem_b[n] = e[n]; eq.push_back(e[n]); end
    rc4_model(kb, eq, 1'b0, d, ok);
    foreach (d[n]) begin exp_addr_b.push_back(n); exp_data_b.push_back(int'(d[n])); end
    exp_valid_b.push_back(ok);
    @(negedge clk); key_b = key; start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    check("busy_b_after_start", busy_b, 1);
    cyc = 1;
    while (!done_b && cyc < BOUND_B) begin @(negedge clk); cyc++; end
    check("done_b_within_bound", done_b, 1);
    @(negedge clk);
    check("valid_b_held", valid_b, 1);
    repeat (3) @(negedge clk);
  endtask

  // Random key; plaintext either random ciphertext, clean lowercase text, or
  // clean text with one out-of-range byte at a random position.
  task automatic random_a(input int mode);
    byte unsigned kb[$], zq[$], ks[$];
    byte unsigned e[5];
    logic [31:0] key;
    bit ok;
    int r, pos;
    byte unsigned p;
    key = $urandom;
    for (int n = 3; n >= 0; n--) kb.push_back(key[8*n +: 8]);
    for (int n = 0; n < 5; n++) zq.push_back(8'h00);
    rc4_model(kb, zq, 1'b0, ks, ok);
    pos = $urandom_range(0, 4);
    for (int n = 0; n < 5; n++) begin
      r = $urandom_range(0, 26);
      p = (r == 26) ? 8'h20 : 8'(8'h61 + r);
      if (mode == 2 && n == pos) p = 8'($urandom_range(8'h21, 8'h60));
      e[n] = (mode == 0) ? 8'($urandom_range(0, 255)) : (p ^ ks[n]);
    end
    run_a(key, e, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    byte unsigned e_wiki[5];
    byte unsigned e_bad[5];
    byte unsigned e_plain[9];
    byte unsigned e_rand[9];
    int cyc;

    reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; key_a = '0; key_b = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl_a", {busy_a, done_a, valid_a, s_we_a, d_we_a}, 0);
    check("reset_bus_a", {s_addr_a, s_wdata_a, d_addr_a, d_wdata_a, e_addr_a}, 0);
    check("reset_ctrl_b", {busy_b, done_b, valid_b, s_we_b, d_we_b}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    e_plain = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    run_b(24'h4B6579, e_plain);
    for (int t = 0; t < 2; t++) begin
      for (int n = 0; n < 9; n++) e_rand[n] = 8'($urandom_range(0, 255));
      run_b(24'($urandom), e_rand);
    end

    e_wiki = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
    run_a(32'h57696B69, e_wiki, 0);
    e_bad = e_wiki;
    e_bad[0] = 8'h30;
    run_a(32'h57696B69, e_bad, 0);
    run_a(32'h57696B69, e_wiki, 256 + 128*5);

    // Reset mid-PRGA: outputs drop at once, no writes follow, rerun is clean.
    begin
      bit ok;
      prep_a(32'h57696B69, e_wiki, ok);
      cyc = 1;
      while (!d_we_a && cyc < BOUND_A) begin @(negedge clk); cyc++; end
      check("prga_reached_before_reset", d_we_a, 1);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("abort_ctrl_a", {busy_a, done_a, valid_a, s_we_a, d_we_a}, 0);
      check("abort_bus_a", {s_addr_a, s_wdata_a, d_addr_a, d_wdata_a, e_addr_a}, 0);
      exp_addr_a.delete(); exp_data_a.delete(); exp_valid_a.delete();
      repeat (5) begin
        @(negedge clk);
        check("no_s_we_in_reset", s_we_a, 0);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    run_a(32'h57696B69, e_wiki, 0);

    for (int t = 0; t < 6; t++) random_a(t % 3);

    repeat (5) @(negedge clk);
    check("leftover_exp_a", exp_valid_a.size(), 0);
    check("leftover_exp_b", exp_valid_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
